// File: rtl/fila_consumer.sv
// fila_consumer: read-side controller for the FILA queue; dequeues, captures after RD_LATENCY and hands bytes to a valid/ready sink.
// Optional request pacing enabled by defining FILA_CONSUMER_PACE_EN.
`timescale 1ns/1ps
module fila_consumer #(
    parameter int RD_LATENCY  = 2,
    parameter int PACE_CYCLES = 4
) (
    input  logic       clock_10KHz,
    input  logic       reset,
    input  logic [3:0] len_in,
    input  logic [7:0] data_in,
    output logic       dequeue_out,
    output logic [7:0] data_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic [7:0] words_out
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;
    localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

    logic [1:0] state;
    logic [2:0] wait_cnt;
    logic       pace_ok;
    logic       start;

    assign start = state == IDLE && len_in != 4'd0 && !valid_out && pace_ok;

`ifdef FILA_CONSUMER_PACE_EN
    logic [7:0] pace;
    assign pace_ok = pace == 8'd0;
    // Loaded as the request is launched so rising edges of dequeue_out are PACE_CYCLES apart.
    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset)
            pace <= 8'd0;
        else if (start)
            pace <= 8'(PACE_CYCLES - 1);
        else if (pace != 8'd0)
            pace <= pace - 8'd1;
    end
`else
    assign pace_ok = PACE_CYCLES > 0;
`endif

    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 3'd0;
            dequeue_out <= 1'b0;
            data_out    <= 8'd0;
            valid_out   <= 1'b0;
            words_out   <= 8'd0;
        end else begin
            dequeue_out <= start;
            case (state)
                IDLE: if (start) state <= REQ;
                REQ: begin
                    state    <= WAIT;
                    wait_cnt <= 3'd0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    if (wait_cnt == LAT_LAST) begin
                        data_out  <= data_in;
                        valid_out <= 1'b1;
                        state     <= HOLD;
                    end
                end
                default: if (valid_out && ready_in) begin
                    valid_out <= 1'b0;
                    words_out <= words_out + 8'd1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
